id_ex_skid_reg: RTL and testbench
=================================

Name: id_ex_skid_reg

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the execute-stage ALU.
- Carries alu_op, both 8-bit operands, destination register index and write-enable.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the ALU side can stall without a combinational ready path back into decode.
- Supports a synchronous flush for branch redirect.

Parameters:
- DATA_W, 8, operand width; must match the ALU input width.
- OP_W, 2, ALU opcode width (00 add, 01 sub, 10 mul, 11 pass in_one).
- RD_W, 3, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  block can accept; equals NOT skid_full, driven from a register only.
- in_alu_op  input  OP_W  opcode from decode.
- in_op_a  input  DATA_W  source operand one.
- in_op_b  input  DATA_W  source operand two.
- in_rd  input  RD_W  destination register.
- in_we  input  1  register write enable.
- out_valid  output  1  output entry valid toward the ALU.
- out_ready  input  1  execute stage consumes this cycle.
- out_alu_op  output  OP_W  to ALU alu_op.
- out_op_a  output  DATA_W  to ALU in_one.
- out_op_b  output  DATA_W  to ALU in_two.
- out_rd  output  RD_W  forwarded to execute/writeback.
- out_we  output  1  forwarded write enable.

Behaviour:
- Storage is two entries: a main (output) register and a skid register, each with its own valid bit. Occupancy is 0, 1 or 2; ordering is strictly FIFO.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready. Data must not change while out_valid=1 and out_ready=0.
- Reset (async assert, sync-safe release):
  - both valid bits 0; all payload registers 0.
  - in_ready=1, out_valid=0, out_alu_op/op_a/op_b/rd/we=0.
- State machine (derived from the valid bits):
  - EMPTY: accept loads main, go to ONE.
  - ONE:
    - consume and accept: main reloads from input, stay ONE.
    - consume only: go to EMPTY.
    - accept only: input goes to skid, go to FULL.
  - FULL: in_ready=0. On consume, skid moves to main, go to ONE. Input is ignored while in FULL.
- Latency: 1 cycle from accept to out_valid when empty. Throughput is 1 per cycle while out_ready stays high.
- in_ready is registered, so it drops the cycle after the skid fills. An accept coinciding with the fill cycle is legal and must land in skid.
- Flush:
  - Next cycle both valid bits are 0 and in_ready=1.
  - Flush overrides any simultaneous accept; that input is dropped.
  - A simultaneous consume still counts as delivered on the output side.
  - Payload registers may hold stale data but must be ignored while invalid.
- Invalid entries: out_we must be gated to 0 whenever out_valid=0.
- Width rules:
  - No arithmetic is performed on payload; it passes through bit-exact.
  - in_we is zeroed on entry when in_rd==0, since register zero is hardwired.
- Reset asserted mid-operation discards all entries immediately (async).

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- When defined:
  - adds output stall_cnt [15:0], which increments each cycle out_valid=1 and out_ready=0.
  - saturates at 16'hFFFF.
  - cleared by rst only; flush does not clear it.
- When undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package (pipe_pkg):
  - ALU opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10, ALU_PASS=2'b11.
  - DATA_W, OP_W, RD_W.
  - packed payload struct id_ex_payload_t {alu_op, op_a, op_b, rd, we}.
- One natural sub-module: skid_entry, a valid bit plus payload register with load/clear, instantiated twice.

Test Plan:
- Reset release, then in_valid=1 with alu_op=00, a=8'h12, b=8'h34, rd=3, we=1, out_ready=1 -> next cycle out_valid=1 with identical payload; then streams one per cycle.
- Hold out_ready=0 and drive three back-to-back inputs (A, B, C):
  - A in main, B in skid, in_ready=0 from the cycle after B.
  - C is held by decode.
  - Release out_ready -> outputs A, B, C in order with no loss or duplicate.
- Occupancy 2, assert flush with in_valid=1 (payload D) -> next cycle out_valid=0, in_ready=1; D never appears on the output.
- in_rd=0 with in_we=1 -> out_we=0 while out_rd=0 and the other fields pass through.
- Assert rst mid-stream with occupancy 2 -> out_valid=0 and all outputs 0 immediately, without waiting for clk.
- With ID_EX_STALL_CNT_EN: out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5. Preload near max -> counter saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, ALU opcodes and ID/EX payload type
package pipe_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;
  localparam int RD_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD  = 2'b00;
  localparam logic [OP_W-1:0] ALU_SUB  = 2'b01;
  localparam logic [OP_W-1:0] ALU_MUL  = 2'b10;
  localparam logic [OP_W-1:0] ALU_PASS = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [RD_W-1:0]   rd;
    logic              we;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/id_ex_skid_reg_if.sv
// rtl/id_ex_skid_reg_if.sv - decode-side and execute-side handshake bundle
interface id_ex_skid_reg_if;
  import pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_alu_op;
  logic [DATA_W-1:0] in_op_a;
  logic [DATA_W-1:0] in_op_b;
  logic [RD_W-1:0]   in_rd;
  logic              in_we;

  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_alu_op;
  logic [DATA_W-1:0] out_op_a;
  logic [DATA_W-1:0] out_op_b;
  logic [RD_W-1:0]   out_rd;
  logic              out_we;

  // master: decode + execute around the register; slave: the register itself
  modport master (
    output in_valid, in_alu_op, in_op_a, in_op_b, in_rd, in_we, out_ready,
    input  in_ready, out_valid, out_alu_op, out_op_a, out_op_b, out_rd, out_we
  );

  modport slave (
    input  in_valid, in_alu_op, in_op_a, in_op_b, in_rd, in_we, out_ready,
    output in_ready, out_valid, out_alu_op, out_op_a, out_op_b, out_rd, out_we
  );

endinterface

// File: rtl/skid_entry.sv
// rtl/skid_entry.sv - one valid bit plus payload register; clear beats load
module skid_entry
  import pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           clr,
  input  id_ex_payload_t d,
  output logic           valid,
  output id_ex_payload_t q
);

  // clear drops only the valid bit; payload may go stale while invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with 2-entry skid; optional ID_EX_STALL_CNT_EN stall counter
module id_ex_skid_reg
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
`ifdef ID_EX_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  id_ex_skid_reg_if.slave       bus
);

  skid_state_t    state_q, state_d;
  logic           in_ready_q;
  logic           accept, consume;
  logic           main_load, main_clr, skid_load, skid_clr;
  logic           main_valid, skid_valid;
  id_ex_payload_t in_pl, main_d, main_q, skid_q;

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = main_valid & bus.out_ready;

  // r0 is hardwired, so a write to it is dropped at the door
  always_comb begin
    in_pl.alu_op = bus.in_alu_op;
    in_pl.op_a   = bus.in_op_a;
    in_pl.op_b   = bus.in_op_b;
    in_pl.rd     = bus.in_rd;
    in_pl.we     = bus.in_we & (bus.in_rd != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = in_pl;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (consume && accept) begin
            main_load = 1'b1;
          end else if (consume) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_d    = skid_q;
            main_load = 1'b1;
            skid_clr  = 1'b1;
            state_d   = ST_ONE;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  skid_entry u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  skid_entry u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clr   (skid_clr),
    .d     (in_pl),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = main_valid;
  assign bus.out_alu_op = main_q.alu_op;
  assign bus.out_op_a   = main_q.op_a;
  assign bus.out_op_b   = main_q.op_b;
  assign bus.out_rd     = main_q.rd;
  assign bus.out_we     = main_q.we & main_valid;

`ifdef ID_EX_STALL_CNT_EN
  // saturating count of cycles the ALU holds off a valid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !bus.out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = skid_valid;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - directed self-checking bench for id_ex_skid_reg
module tb_id_ex_skid_reg;

  logic clk = 1'b0;
  logic rst;
  logic flush;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  id_ex_skid_reg_if bus();

  id_ex_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] pk(logic [1:0] op, logic [7:0] a, logic [7:0] b,
                                     logic [2:0] rd, logic we);
    return {op, a, b, rd, we};
  endfunction

  function automatic logic [21:0] out_pk();
    return {bus.out_alu_op, bus.out_op_a, bus.out_op_b, bus.out_rd, bus.out_we};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [2:0] rd, input logic we);
    bus.in_valid  = v;
    bus.in_alu_op = op;
    bus.in_op_a   = a;
    bus.in_op_b   = b;
    bus.in_rd     = rd;
    bus.in_we     = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_payload", {10'd0, out_pk()}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // single transfer then streaming at one per cycle
    bus.out_ready = 1'b1;
    drv(1'b1, 2'b00, 8'h12, 8'h34, 3'd3, 1'b1);
    tick();
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_payload", {10'd0, out_pk()}, {10'd0, pk(2'b00, 8'h12, 8'h34, 3'd3, 1'b1)});
    drv(1'b1, 2'b01, 8'h56, 8'h78, 3'd5, 1'b1);
    tick();
    chk("stream_p2", {10'd0, out_pk()}, {10'd0, pk(2'b01, 8'h56, 8'h78, 3'd5, 1'b1)});
    drv(1'b1, 2'b10, 8'h9a, 8'hbc, 3'd7, 1'b0);
    tick();
    chk("stream_p3", {10'd0, out_pk()}, {10'd0, pk(2'b10, 8'h9a, 8'hbc, 3'd7, 1'b0)});
    chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // backpressure: A, B fill both entries, C is held by decode
    bus.out_ready = 1'b0;
    drv(1'b1, 2'b00, 8'hA1, 8'hA2, 3'd1, 1'b1);
    tick();
    chk("bp_A_out", {10'd0, out_pk()}, {10'd0, pk(2'b00, 8'hA1, 8'hA2, 3'd1, 1'b1)});
    chk("bp_ready_one", {31'd0, bus.in_ready}, 32'd1);
    drv(1'b1, 2'b01, 8'hB1, 8'hB2, 3'd2, 1'b1);
    tick();
    chk("bp_ready_full", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_A_hold", {10'd0, out_pk()}, {10'd0, pk(2'b00, 8'hA1, 8'hA2, 3'd1, 1'b1)});
    drv(1'b1, 2'b10, 8'hC1, 8'hC2, 3'd4, 1'b0);
    tick();
    chk("bp_A_hold2", {10'd0, out_pk()}, {10'd0, pk(2'b00, 8'hA1, 8'hA2, 3'd1, 1'b1)});
    chk("bp_ready_full2", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_B_out", {10'd0, out_pk()}, {10'd0, pk(2'b01, 8'hB1, 8'hB2, 3'd2, 1'b1)});
    chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_C_out", {10'd0, out_pk()}, {10'd0, pk(2'b10, 8'hC1, 8'hC2, 3'd4, 1'b0)});
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // flush at occupancy two with a pending input D
    bus.out_ready = 1'b0;
    drv(1'b1, 2'b00, 8'h11, 8'h22, 3'd1, 1'b1);
    tick();
    drv(1'b1, 2'b00, 8'h33, 8'h44, 3'd2, 1'b1);
    tick();
    chk("fl_full_ready", {31'd0, bus.in_ready}, 32'd0);
    flush = 1'b1;
    drv(1'b1, 2'b11, 8'hDD, 8'hDE, 3'd6, 1'b1);
    tick();
    chk("fl_full_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_full_ready1", {31'd0, bus.in_ready}, 32'd1);
    flush = 1'b0;
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    chk("fl_full_noD", {31'd0, bus.out_valid}, 32'd0);

    // flush in ONE overrides a simultaneous accept
    drv(1'b1, 2'b01, 8'hE1, 8'hE2, 3'd3, 1'b1);
    tick();
    flush = 1'b1;
    drv(1'b1, 2'b11, 8'hDD, 8'hDE, 3'd6, 1'b1);
    tick();
    chk("fl_one_valid", {31'd0, bus.out_valid}, 32'd0);
    flush = 1'b0;
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    chk("fl_one_noD", {31'd0, bus.out_valid}, 32'd0);

    // rd == 0 suppresses the write enable; other fields pass through
    bus.out_ready = 1'b1;
    drv(1'b1, 2'b11, 8'hAA, 8'h55, 3'd0, 1'b1);
    tick();
    chk("r0_payload", {10'd0, out_pk()}, {10'd0, pk(2'b11, 8'hAA, 8'h55, 3'd0, 1'b0)});
    drv(1'b1, 2'b00, 8'h01, 8'h02, 3'd2, 1'b1);
    tick();
    chk("we_live", {31'd0, bus.out_we}, 32'd1);
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    chk("we_gated_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("we_gated", {31'd0, bus.out_we}, 32'd0);

    // asynchronous reset with both entries occupied
    bus.out_ready = 1'b0;
    drv(1'b1, 2'b10, 8'h77, 8'h88, 3'd5, 1'b1);
    tick();
    drv(1'b1, 2'b01, 8'h99, 8'h66, 3'd4, 1'b1);
    tick();
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_payload", {10'd0, out_pk()}, 32'd0);
    chk("ar_ready", {31'd0, bus.in_ready}, 32'd1);
    #2;
    rst = 1'b0;
    tick();
    chk("ar_stays_empty", {31'd0, bus.out_valid}, 32'd0);

`ifdef ID_EX_STALL_CNT_EN
    chk("sc_zero", {16'd0, stall_cnt}, 32'd0);
    bus.out_ready = 1'b0;
    drv(1'b1, 2'b00, 8'h05, 8'h06, 3'd1, 1'b1);
    tick();
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("sc_start", {16'd0, stall_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("sc_five", {16'd0, stall_cnt}, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sc_flush_keeps", {16'd0, stall_cnt}, 32'd6);
    drv(1'b1, 2'b00, 8'h07, 8'h08, 3'd1, 1'b1);
    tick();
    drv(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 65540; i++) tick();
    chk("sc_saturate", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
